// File: rtl/mm_job_scheduler_pkg.sv
// Shared types and constants for the matrix-multiply job scheduler.
// Holds the FSM state enum, the job descriptor struct and the beat-count
// widths, plus helpers that compute the expected F and W beat counts.
package mm_job_scheduler_pkg;

   localparam int unsigned A_SIZE  = 16;
   localparam int unsigned SHIFT_W = 10;
   localparam int unsigned FLEN_W  = 9;
   localparam int unsigned FBLK_W  = 5;
   localparam int unsigned WBLK_W  = 5;
   localparam int unsigned TAG_W   = 4;
   localparam int unsigned QDEPTH  = 4;
   localparam int unsigned SETTLE  = 3;

   localparam int unsigned QPTR_W   = $clog2(QDEPTH);
   localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
   // Wide enough for the largest product, so no beat count is ever truncated
   localparam int unsigned FBEAT_W  = FLEN_W + FBLK_W;
   localparam int unsigned WBEAT_W  = $clog2(A_SIZE) + FBLK_W + WBLK_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CFG   = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic [SHIFT_W-1:0] shift;
      logic [FLEN_W-1:0]  flen;
      logic [FBLK_W-1:0]  fblk;
      logic [WBLK_W-1:0]  wblk;
      logic [TAG_W-1:0]   tag;
   } job_desc_t;

   localparam int unsigned DESC_W = $bits(job_desc_t);

   // F beats per job: rows times width blocks
   function automatic logic [FBEAT_W-1:0] f_beats(input job_desc_t d);
      return FBEAT_W'(d.flen) * FBEAT_W'(d.fblk);
   endfunction

   // W beats per job: one block of A_SIZE rows per (fblk, wblk) pair
   function automatic logic [WBEAT_W-1:0] w_beats(input job_desc_t d);
      return WBEAT_W'(A_SIZE) * WBEAT_W'(d.fblk) * WBEAT_W'(d.wblk);
   endfunction

endpackage

// File: rtl/mm_sched_desc_fifo.sv
// Synchronous FIFO of job descriptors.
// Ports: clk, rst (sync, active-high); push_i/din_i write side; pop_i/dout_o
// read side (dout_o shows the head combinationally from storage);
// ready_o = registered not-full (low during reset); empty_o = no entries.
module mm_sched_desc_fifo
   import mm_job_scheduler_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      push_i,
   input  job_desc_t din_i,
   input  logic      pop_i,
   output job_desc_t dout_o,
   output logic      ready_o,
   output logic      empty_o
);

   logic [DESC_W-1:0] mem_q [QDEPTH];
   logic [QPTR_W-1:0] wr_ptr_q;
   logic [QPTR_W-1:0] rd_ptr_q;
   logic [QPTR_W:0]   count_q;
   logic [QPTR_W:0]   count_d;
   logic              ready_q;
   logic              do_push;
   logic              do_pop;

   assign empty_o = (count_q == '0);
   assign ready_o = ready_q;
   assign dout_o  = job_desc_t'(mem_q[rd_ptr_q]);
   // A push is only taken while ready; ready stays low at full even if a pop happens
   assign do_push = push_i && ready_q;
   assign do_pop  = pop_i && !empty_o;

   // Occupancy update
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (QPTR_W+1)'(1);
         2'b01:   count_d = count_q - (QPTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy and registered ready
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + QPTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + QPTR_W'(1);
         count_q <= count_d;
         ready_q <= (count_d != (QPTR_W+1)'(QDEPTH));
      end
   end

   // Storage, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/mm_job_scheduler.sv
// Sequences the matrix-multiply engine one job at a time.
// Ports: job_* descriptor push (job_ready = queue not full); cfg_* held config
// to the engine; s_f_*/m_f_* and s_w_*/m_w_* gated F/W streams (pass-through
// only while running and below the expected beat count); eng_out_* monitor
// of the engine output handshake; busy, done_valid/done_tag completion pulse,
// err sticky stream-length mismatch.
// Optional: define MM_SCHED_PERF_EN to add perf_cycles, the cycle count from
// CFG entry to the done pulse (saturating, latched with done_valid).
module mm_job_scheduler
   import mm_job_scheduler_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [SHIFT_W-1:0] job_shift,
   input  logic [FLEN_W-1:0]  job_flen,
   input  logic [FBLK_W-1:0]  job_fblk,
   input  logic [WBLK_W-1:0]  job_wblk,
   input  logic [TAG_W-1:0]   job_tag,
   output logic [SHIFT_W-1:0] cfg_shift,
   output logic [FLEN_W-1:0]  cfg_flen,
   output logic [FBLK_W-1:0]  cfg_fblk,
   output logic [WBLK_W-1:0]  cfg_wblk,
   input  logic               s_f_valid,
   input  logic               s_f_last,
   output logic               s_f_ready,
   output logic               m_f_valid,
   output logic               m_f_last,
   input  logic               m_f_ready,
   input  logic               s_w_valid,
   input  logic               s_w_last,
   output logic               s_w_ready,
   output logic               m_w_valid,
   output logic               m_w_last,
   input  logic               m_w_ready,
   input  logic               eng_out_valid,
   input  logic               eng_out_ready,
   input  logic               eng_out_last,
   output logic               busy,
   output logic               done_valid,
   output logic [TAG_W-1:0]   done_tag,
   output logic               err
`ifdef MM_SCHED_PERF_EN
   ,
   output logic [31:0]        perf_cycles
`endif
);

   sched_state_e        state_q, state_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   job_desc_t           desc_q, desc_d;
   logic [FBEAT_W-1:0]  f_exp_q, f_exp_d, f_cnt_q, f_cnt_d;
   logic [WBEAT_W-1:0]  w_exp_q, w_exp_d, w_cnt_q, w_cnt_d;
   logic                eng_seen_q, eng_seen_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [TAG_W-1:0]    done_tag_q, done_tag_d;
   logic                err_q, err_d;

   job_desc_t           fifo_din;
   job_desc_t           fifo_dout;
   logic                fifo_ready;
   logic                fifo_empty;
   logic                fifo_pop;

   logic                f_open, w_open;
   logic                f_fire, w_fire;
   logic                eng_fire;

   assign fifo_din = '{shift: job_shift, flen: job_flen, fblk: job_fblk,
                       wblk: job_wblk, tag: job_tag};
   assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

   mm_sched_desc_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (job_valid),
      .din_i   (fifo_din),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .ready_o (fifo_ready),
      .empty_o (fifo_empty)
   );

   // Each stream is open in RUN until its own count is reached; rst closes at once
   assign f_open = (state_q == ST_RUN) && (f_cnt_q != f_exp_q) && !rst;
   assign w_open = (state_q == ST_RUN) && (w_cnt_q != w_exp_q) && !rst;

   assign m_f_valid = f_open && s_f_valid;
   assign m_f_last  = f_open && s_f_last;
   assign s_f_ready = f_open && m_f_ready;
   assign m_w_valid = w_open && s_w_valid;
   assign m_w_last  = w_open && s_w_last;
   assign s_w_ready = w_open && m_w_ready;

   assign f_fire   = f_open && s_f_valid && m_f_ready;
   assign w_fire   = w_open && s_w_valid && m_w_ready;
   assign eng_fire = eng_out_valid && eng_out_ready && eng_out_last;

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      desc_d     = desc_q;
      f_exp_d    = f_exp_q;
      w_exp_d    = w_exp_q;
      f_cnt_d    = f_cnt_q;
      w_cnt_d    = w_cnt_q;
      eng_seen_d = eng_seen_q;
      done_d     = 1'b0;
      done_tag_d = done_tag_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (fifo_pop) begin
               desc_d     = fifo_dout;
               f_exp_d    = f_beats(fifo_dout);
               w_exp_d    = w_beats(fifo_dout);
               f_cnt_d    = '0;
               w_cnt_d    = '0;
               settle_d   = '0;
               eng_seen_d = 1'b0;
               state_d    = ST_CFG;
            end
         end
         ST_CFG: begin
            // Hold config long enough for the engine's delayed sampling
            if (settle_q == SETTLE_W'(SETTLE - 1)) begin
               state_d = ST_RUN;
            end else begin
               settle_d = settle_q + SETTLE_W'(1);
            end
         end
         ST_RUN: begin
            // Last must coincide exactly with the final counted beat
            if (f_fire) begin
               f_cnt_d = f_cnt_q + FBEAT_W'(1);
               if (s_f_last != (f_cnt_d == f_exp_q)) err_d = 1'b1;
            end
            if (w_fire) begin
               w_cnt_d = w_cnt_q + WBEAT_W'(1);
               if (s_w_last != (w_cnt_d == w_exp_q)) err_d = 1'b1;
            end
            // An early engine last is remembered and honoured in DRAIN
            if (eng_fire) eng_seen_d = 1'b1;
            if ((f_cnt_q == f_exp_q) && (w_cnt_q == w_exp_q)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (eng_seen_q || eng_fire) begin
               done_d     = 1'b1;
               done_tag_d = desc_q.tag;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         settle_q   <= '0;
         desc_q     <= '0;
         f_exp_q    <= '0;
         w_exp_q    <= '0;
         f_cnt_q    <= '0;
         w_cnt_q    <= '0;
         eng_seen_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         done_tag_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         desc_q     <= desc_d;
         f_exp_q    <= f_exp_d;
         w_exp_q    <= w_exp_d;
         f_cnt_q    <= f_cnt_d;
         w_cnt_q    <= w_cnt_d;
         eng_seen_q <= eng_seen_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         done_tag_q <= done_tag_d;
         err_q      <= err_d;
      end
   end

   assign job_ready  = fifo_ready;
   assign cfg_shift  = desc_q.shift;
   assign cfg_flen   = desc_q.flen;
   assign cfg_fblk   = desc_q.fblk;
   assign cfg_wblk   = desc_q.wblk;
   assign busy       = busy_q;
   assign done_valid = done_q;
   assign done_tag   = done_tag_q;
   assign err        = err_q;

`ifdef MM_SCHED_PERF_EN
   logic [31:0] perf_cnt_q, perf_cnt_d;
   logic [31:0] perf_cycles_q, perf_cycles_d;
   logic [31:0] perf_inc;

   // Saturating cycle count over every non-IDLE cycle of the job
   assign perf_inc = (&perf_cnt_q) ? perf_cnt_q : perf_cnt_q + 32'd1;

   always_comb begin
      perf_cnt_d    = perf_cnt_q;
      perf_cycles_d = perf_cycles_q;
      if (state_q == ST_IDLE) perf_cnt_d = '0;
      else                    perf_cnt_d = perf_inc;
      if (done_d) perf_cycles_d = perf_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cnt_q    <= '0;
         perf_cycles_q <= '0;
      end else begin
         perf_cnt_q    <= perf_cnt_d;
         perf_cycles_q <= perf_cycles_d;
      end
   end

   assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_mm_job_scheduler.sv
`timescale 1ns/1ps
module tb_mm_job_scheduler;
   import mm_job_scheduler_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               job_valid, job_ready;
   logic [SHIFT_W-1:0] job_shift;
   logic [FLEN_W-1:0]  job_flen;
   logic [FBLK_W-1:0]  job_fblk;
   logic [WBLK_W-1:0]  job_wblk;
   logic [TAG_W-1:0]   job_tag;
   logic [SHIFT_W-1:0] cfg_shift;
   logic [FLEN_W-1:0]  cfg_flen;
   logic [FBLK_W-1:0]  cfg_fblk;
   logic [WBLK_W-1:0]  cfg_wblk;
   logic s_f_valid, s_f_last, s_f_ready, m_f_valid, m_f_last, m_f_ready;
   logic s_w_valid, s_w_last, s_w_ready, m_w_valid, m_w_last, m_w_ready;
   logic eng_out_valid, eng_out_ready, eng_out_last;
   logic busy, done_valid, err;
   logic [TAG_W-1:0] done_tag;

   mm_job_scheduler dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_shift(job_shift), .job_flen(job_flen), .job_fblk(job_fblk),
      .job_wblk(job_wblk), .job_tag(job_tag),
      .cfg_shift(cfg_shift), .cfg_flen(cfg_flen), .cfg_fblk(cfg_fblk), .cfg_wblk(cfg_wblk),
      .s_f_valid(s_f_valid), .s_f_last(s_f_last), .s_f_ready(s_f_ready),
      .m_f_valid(m_f_valid), .m_f_last(m_f_last), .m_f_ready(m_f_ready),
      .s_w_valid(s_w_valid), .s_w_last(s_w_last), .s_w_ready(s_w_ready),
      .m_w_valid(m_w_valid), .m_w_last(m_w_last), .m_w_ready(m_w_ready),
      .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_out_last(eng_out_last),
      .busy(busy), .done_valid(done_valid), .done_tag(done_tag), .err(err)
   );

   // One job: descriptor, how the sources behave, and hand-computed expectations
   typedef struct {
      logic [SHIFT_W-1:0] shift;
      logic [FLEN_W-1:0]  flen;
      logic [FBLK_W-1:0]  fblk;
      logic [WBLK_W-1:0]  wblk;
      logic [TAG_W-1:0]   tag;
      int f_total; int f_last_at;
      int w_total; int w_last_at;
      bit w_bp;    int eng_early;
      bit exp_err; int exp_f; int exp_w;
   } vec_t;

   vec_t tbl[11];

   int n_cmp = 0;
   int n_bad = 0;

   int pushed, done_n, cur;
   int f_sent, w_sent, f_pass, w_pass;
   bit eng_sent, first_seen, over_chk, push_seen;
   int stable = 0;
   logic [28:0] prev_cfg = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clear_job();
      f_sent = 0; w_sent = 0; f_pass = 0; w_pass = 0;
      eng_sent = 0; first_seen = 0; over_chk = 0;
   endtask

   task automatic idle_inputs();
      job_valid = 0; s_f_valid = 0; s_f_last = 0; s_w_valid = 0; s_w_last = 0;
      m_f_ready = 1; m_w_ready = 1;
      eng_out_valid = 0; eng_out_ready = 0; eng_out_last = 0;
   endtask

   // Drive upstream sources, engine ready and the engine output monitor
   task automatic drive(input int c);
      vec_t v;
      bit go;
      v = tbl[cur];
      s_f_valid = (f_sent < v.f_total);
      s_f_last  = s_f_valid && (f_sent + 1 == v.f_last_at);
      s_w_valid = (w_sent < v.w_total);
      s_w_last  = s_w_valid && (w_sent + 1 == v.w_last_at);
      m_f_ready = 1'b1;
      m_w_ready = v.w_bp ? (c % 2 == 1) : 1'b1;
      if (v.eng_early > 0) go = !eng_sent && (w_pass >= v.eng_early);
      else                 go = !eng_sent && (f_pass >= v.exp_f) && (w_pass >= v.exp_w);
      eng_out_valid = go; eng_out_ready = go; eng_out_last = go;
   endtask

   // Sample just before the active edge: record handshakes and check completions
   task automatic sample();
      vec_t v;
      logic [28:0] cur_cfg;
      v = tbl[cur];
      push_seen = job_valid && job_ready;
      cur_cfg = {cfg_shift, cfg_flen, cfg_fblk, cfg_wblk};
      if (cur_cfg != prev_cfg) stable = 0; else stable++;
      prev_cfg = cur_cfg;
      if (!first_seen && (m_f_valid || m_w_valid)) begin
         first_seen = 1;
         chk("cfg_value", 64'(cur_cfg), 64'({v.shift, v.flen, v.fblk, v.wblk}));
         chk("cfg_settled_3", 64'(stable >= 3), 64'd1);
         chk("busy_in_run", 64'(busy), 64'd1);
      end
      if (!over_chk && (v.f_total > v.exp_f) && (f_pass == v.exp_f) && s_f_valid) begin
         over_chk = 1;
         chk("f_extra_beat_blocked", 64'(s_f_ready), 64'd0);
      end
      if (s_f_valid && s_f_ready) f_sent++;
      if (s_w_valid && s_w_ready) w_sent++;
      if (m_f_valid && m_f_ready) f_pass++;
      if (m_w_valid && m_w_ready) w_pass++;
      if (eng_out_valid) eng_sent = 1;
      if (done_valid) begin
         chk("done_tag", 64'(done_tag), 64'(v.tag));
         chk("f_beats", 64'(f_pass), 64'(v.exp_f));
         chk("w_beats", 64'(w_pass), 64'(v.exp_w));
         chk("err", 64'(err), 64'(v.exp_err));
         done_n++;
         cur++;
         clear_job();
      end
   endtask

   // Push n table jobs and service them until n completions or stop_f F beats
   task automatic run_jobs(input int first, input int n, input bit chk_full, input int stop_f);
      bit full_checked;
      bit stopped;
      full_checked = 0; stopped = 0;
      pushed = 0; done_n = 0; cur = first;
      clear_job();
      for (int c = 0; c < 3000 && done_n < n && !stopped; c++) begin
         job_valid = (pushed < n);
         if (pushed < n) begin
            job_shift = tbl[first+pushed].shift; job_flen = tbl[first+pushed].flen;
            job_fblk  = tbl[first+pushed].fblk;  job_wblk = tbl[first+pushed].wblk;
            job_tag   = tbl[first+pushed].tag;
         end
         drive(c);
         @(negedge clk);
         sample();
         if (push_seen) pushed++;
         if (stop_f > 0 && f_pass >= stop_f) stopped = 1;
         @(posedge clk); #1;
         if (chk_full && !full_checked && pushed == n) begin
            full_checked = 1;
            chk("job_ready_full", 64'(job_ready), 64'd0);
         end
      end
      if (stop_f > 0) chk("reached_stop_beats", 64'(f_pass >= stop_f), 64'd1);
      else            chk("jobs_completed", 64'(done_n), 64'(n));
      job_valid = 0;
   endtask

   initial begin
      bit saw_done, saw_busy;
      //            shift    flen fblk wblk tag  fT fL  wT wL bp early err eF eW
      tbl[0]  = '{10'h015, 9'd4, 5'd2, 5'd1, 4'd9,  8, 8, 32, 32, 0, 0,  0, 8, 32};
      tbl[1]  = '{10'h001, 9'd3, 5'd1, 5'd1, 4'd0,  3, 3, 16, 16, 0, 0,  0, 3, 16};
      tbl[2]  = '{10'h002, 9'd2, 5'd1, 5'd1, 4'd1,  2, 2, 16, 16, 0, 0,  0, 2, 16};
      tbl[3]  = '{10'h3ff, 9'd1, 5'd2, 5'd2, 4'd2,  2, 2, 64, 64, 0, 0,  0, 2, 64};
      tbl[4]  = '{10'h004, 9'd5, 5'd1, 5'd2, 4'd3,  5, 5, 32, 32, 0, 0,  0, 5, 32};
      tbl[5]  = '{10'h105, 9'd2, 5'd3, 5'd1, 4'd4,  6, 6, 48, 48, 0, 0,  0, 6, 48};
      tbl[6]  = '{10'h006, 9'd4, 5'd2, 5'd1, 4'd5,  8, 8, 32, 32, 1, 0,  0, 8, 32};
      tbl[7]  = '{10'h007, 9'd2, 5'd1, 5'd2, 4'd6,  2, 2, 32, 32, 0, 10, 0, 2, 32};
      tbl[8]  = '{10'h008, 9'd4, 5'd2, 5'd1, 4'd7, 10, 10, 32, 32, 0, 0, 1, 8, 32};
      tbl[9]  = '{10'h009, 9'd6, 5'd1, 5'd1, 4'd8,  6, 6, 16, 16, 0, 0,  0, 6, 16};
      tbl[10] = '{10'h00a, 9'd2, 5'd1, 5'd1, 4'd10, 2, 2, 16, 16, 0, 0,  0, 2, 16};

      // Reset with live upstream traffic: everything must stay closed
      idle_inputs();
      job_shift = '0; job_flen = '0; job_fblk = '0; job_wblk = '0; job_tag = '0;
      rst = 1; s_f_valid = 1; s_w_valid = 1; job_valid = 1;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("rst_job_ready", 64'(job_ready), 64'd0);
      chk("rst_cfg", 64'({cfg_shift, cfg_flen, cfg_fblk, cfg_wblk}), 64'd0);
      chk("rst_m_f_valid", 64'(m_f_valid), 64'd0);
      chk("rst_s_w_ready", 64'(s_w_ready), 64'd0);
      chk("rst_flags", 64'({busy, done_valid, done_tag, err}), 64'd0);
      idle_inputs();
      rst = 0;
      @(posedge clk); #1;
      chk("job_ready_after_rst", 64'(job_ready), 64'd1);

      run_jobs(0, 1, 0, 0);   // single job
      run_jobs(1, 5, 1, 0);   // filler job then tags 1..4 fill the queue
      run_jobs(6, 1, 0, 0);   // W backpressure every other cycle
      run_jobs(7, 1, 0, 0);   // engine last arrives during RUN
      run_jobs(8, 1, 0, 0);   // 10 F beats offered for 8 expected, last misplaced

      // Reset mid-RUN after 3 F beats, with a second job waiting in the queue
      run_jobs(9, 2, 0, 3);
      rst = 1;
      @(negedge clk);
      chk("rst_closes_f_now", 64'(m_f_valid), 64'd0);
      @(posedge clk); #1;
      chk("midrst_job_ready", 64'(job_ready), 64'd0);
      chk("midrst_cfg", 64'({cfg_shift, cfg_flen, cfg_fblk, cfg_wblk}), 64'd0);
      chk("midrst_streams", 64'({m_f_valid, s_f_ready, m_w_valid, s_w_ready}), 64'd0);
      chk("midrst_flags", 64'({busy, done_valid, done_tag, err}), 64'd0);
      rst = 0;
      idle_inputs();
      saw_done = 0; saw_busy = 0;
      repeat (12) begin
         @(posedge clk); #1;
         saw_done |= done_valid;
         saw_busy |= busy;
      end
      chk("midrst_no_done", 64'(saw_done), 64'd0);
      chk("midrst_queue_flushed", 64'(saw_busy), 64'd0);
      chk("midrst_ready_back", 64'(job_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mm_job_scheduler.md
Name: mm_job_scheduler

Overview:
- Sequences the matrix-multiply engine one job at a time.
- Accepts job descriptors (shift, F_length, F block count, W block count, tag) through a small queue and drives them onto the engine's configuration inputs, holding them stable.
- Gates the F and W input streams into the engine only while a job is running, checks beat counts, and retires the job on the engine's output last beat.
- Sits between the host DMA/command path and the engine.

Parameters:
- A_SIZE, 16, systolic array dimension; one beat = A_SIZE lanes
- SHIFT_W, 10, shift field width
- FLEN_W, 9, F_length field width
- FBLK_W, 5, F width block count width
- WBLK_W, 5, W width block count width
- TAG_W, 4, job tag width
- QDEPTH, 4, descriptor queue depth (power of 2)
- SETTLE, 3, cycles config is held before streams open (engine samples config changes with a 2-cycle lag)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- job_valid  in  1  descriptor valid
- job_ready  out  1  queue not full
- job_shift  in  SHIFT_W  requantisation shift
- job_flen  in  FLEN_W  feature length (rows), 1..2^FLEN_W-1
- job_fblk  in  FBLK_W  feature width in blocks, >=1
- job_wblk  in  WBLK_W  weight width in blocks, >=1
- job_tag  in  TAG_W  returned on completion
- cfg_shift / cfg_flen / cfg_fblk / cfg_wblk  out  field widths  to engine config inputs
- s_f_valid / s_f_last / s_f_ready  in/in/out  1 each  upstream F stream
- m_f_valid / m_f_last / m_f_ready  out/out/in  1 each  to engine F input
- s_w_valid / s_w_last / s_w_ready, m_w_*  same for W stream
- eng_out_valid / eng_out_ready / eng_out_last  in  1 each  monitor of engine output handshake
- busy  out  1  job active
- done_valid  out  1  one-cycle completion pulse
- done_tag  out  TAG_W  tag of completed job
- err  out  1  sticky; stream length mismatch

Behaviour:
- Reset values: job_ready=0 during rst, 1 the cycle after; all cfg_*=0; m_*_valid=0; s_*_ready=0; busy=0; done_valid=0; done_tag=0; err=0. Queue emptied. FSM to IDLE.
- Queue: FIFO; push on job_valid&&job_ready; job_ready = !full. Push while full is impossible. Simultaneous push and pop at full is allowed; job_ready stays low that cycle.
- FSM states:
  - IDLE: if queue non-empty, pop the head, register it into cfg_* and tag, go to CFG. busy=1 from the next cycle.
  - CFG: count SETTLE cycles, then go to RUN. Streams are closed.
  - RUN: streams are pass-through. m_x_valid=s_x_valid, s_x_ready=m_x_ready, last is passed, per stream x.
    - F beat counter runs to F_EXP = flen*fblk; W counter runs to W_EXP = A_SIZE*fblk*wblk.
    - Counter widths are sized for the maximum product with no truncation.
    - Each stream closes independently after its expected count. Its ready is forced 0 and its valid is masked.
    - When both have closed, go to DRAIN.
    - Mismatch sets err: a last on the final counted beat is required, and a last on any other beat is an error. The counts still govern closure.
  - DRAIN: wait for eng_out_valid&&eng_out_ready&&eng_out_last. Then done_valid=1 for one cycle, done_tag=tag, go to IDLE.
    - An eng_out_last arriving during RUN is also accepted; it is recorded and honoured on entering DRAIN.
- cfg_* hold their value after a job completes and until the next pop, so there are no spurious config edges.
- Back-to-back: IDLE to CFG of the next job takes one cycle after done.
- Rst mid-job: streams close immediately, the queue is flushed, and no done pulse is issued.
- err is cleared only by rst.

Optional Feature:
- MM_SCHED_PERF_EN:
  - When defined, adds output perf_cycles (32 bits). It counts clk cycles from CFG entry to the done pulse and is latched with done_valid. It saturates at all-ones and resets to 0.
  - When undefined, the port and counter are absent.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, CFG, RUN, DRAIN);
  - the descriptor struct {shift, flen, fblk, wblk, tag} with its packed width;
  - the beat-count width constants derived from FLEN_W+FBLK_W and log2(A_SIZE)+FBLK_W+WBLK_W.
- One sub-module: mm_sched_desc_fifo, a synchronous FIFO of descriptor structs with full/empty.

Test Plan:
- Single job, flen=4, fblk=2, wblk=1, A_SIZE=16:
  - cfg stable ≥3 cycles before the first m_f_valid;
  - exactly 8 F and 32 W beats pass;
  - done_valid pulses with the tag after eng_out_last; err=0.
- Four jobs queued back-to-back (tags 1–4): job_ready drops after 4 pushes; done tags come out in order 1,2,3,4 with no stream beats overlapping across jobs.
- Upstream F presents 10 beats for F_EXP=8: beat 9 is not accepted (s_f_ready=0 after 8); err=1 because the last was not on beat 8.
- eng_out_last asserted while W is still streaming: the job completes on DRAIN entry without waiting again.
- rst asserted mid-RUN after 3 F beats: all outputs return to reset values next cycle, no done_valid, queue empty.
- Backpressure: m_w_ready toggles every cycle; the W count is still exactly 32 and completion is correct.
